// File: rtl/cache_rd_arbiter.sv
// Round-robin arbiter sharing one cache-side read port of the AXI bridge
// among NREQ requesters (0 = icache, 1 = dcache, 2 = uncached). Exactly one
// read is in flight; the returned block is routed to the granted requester.
module cache_rd_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [3*NREQ-1:0]    req_type,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [3*NREQ-1:0]    req_size,
  output logic [NREQ-1:0]      req_rdy,
  output logic [NREQ-1:0]      ret_valid,
  output logic [127:0]         ret_data,
  output logic                 mem_rd_req,
  output logic [2:0]           mem_rd_type,
  output logic [31:0]          mem_rd_addr,
  output logic [2:0]           mem_rd_size,
  input  logic                 mem_rd_rdy,
  input  logic                 mem_ret_valid,
  input  logic [127:0]         mem_ret_data,
  output logic                 protocol_err
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    WAIT  = 4'b0100,
    RESP  = 4'b1000
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_q;
  logic [PTR_W-1:0] grant;
  logic [PTR_W-1:0] next_ptr;
  logic             any_req;
  logic [2:0]       sel_type;
  logic [2:0]       sel_size;
  logic [31:0]      sel_addr;

  // Cyclic priority search starting at rr_ptr; first valid requester wins.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    grant   = '0;
    any_req = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = (32'(rr_ptr) + off) % NREQ;
      if (!any_req && req_valid[idx[PTR_W-1:0]]) begin
        any_req = 1'b1;
        grant   = idx[PTR_W-1:0];
      end
    end
  end

  // Select the granted requester's fields and compute the wrapped pointer.
  always_comb begin
    sel_type = '0;
    sel_size = '0;
    sel_addr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant == PTR_W'(i)) begin
        sel_type = req_type[3*i +: 3];
        sel_size = req_size[3*i +: 3];
        sel_addr = req_addr[32*i +: 32];
      end
    end
    next_ptr = (32'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
  end

  // Accept strobe: only in IDLE, one-hot at the current grant.
  always_comb begin
    req_rdy = '0;
    if (state == IDLE && any_req) req_rdy[grant] = 1'b1;
  end

  // Return pulse to the requester that owns the in-flight read.
  always_comb begin
    ret_valid = '0;
    if (state == RESP) ret_valid[grant_q] = 1'b1;
  end

  assign mem_rd_req = (state == ISSUE);

  // Transaction FSM with latched request/return fields and sticky error flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant_q      <= '0;
      mem_rd_type  <= '0;
      mem_rd_addr  <= '0;
      mem_rd_size  <= '0;
      ret_data     <= '0;
      protocol_err <= 1'b0;
    end else begin
      // Any return outside WAIT (including the ISSUE handshake cycle) is stray.
      if (mem_ret_valid && state != WAIT) protocol_err <= 1'b1;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_q     <= grant;
            mem_rd_type <= sel_type;
            mem_rd_addr <= sel_addr;
            mem_rd_size <= (sel_type == 3'b100) ? 3'd2 : sel_size;
            rr_ptr      <= next_ptr;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_rd_rdy) state <= WAIT;
        end
        WAIT: begin
          if (mem_ret_valid) begin
            ret_data <= mem_ret_data;
            state    <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Directed testbench for cache_rd_arbiter. Inputs are driven on the falling
// edge and outputs are sampled 1 time unit later, well away from posedge.
module tb_cache_rd_arbiter;

  logic         clk;
  logic         resetn;
  logic [2:0]   req_valid;
  logic [8:0]   req_type;
  logic [95:0]  req_addr;
  logic [8:0]   req_size;
  logic [2:0]   req_rdy;
  logic [2:0]   ret_valid;
  logic [127:0] ret_data;
  logic         mem_rd_req;
  logic [2:0]   mem_rd_type;
  logic [31:0]  mem_rd_addr;
  logic [2:0]   mem_rd_size;
  logic         mem_rd_rdy;
  logic         mem_ret_valid;
  logic [127:0] mem_ret_data;
  logic         protocol_err;

  int checks;
  int errors;

  cache_rd_arbiter #(.NREQ(3), .PTR_W(2)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_type      (req_type),
    .req_addr      (req_addr),
    .req_size      (req_size),
    .req_rdy       (req_rdy),
    .ret_valid     (ret_valid),
    .ret_data      (ret_data),
    .mem_rd_req    (mem_rd_req),
    .mem_rd_type   (mem_rd_type),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_size   (mem_rd_size),
    .mem_rd_rdy    (mem_rd_rdy),
    .mem_ret_valid (mem_ret_valid),
    .mem_ret_data  (mem_ret_data),
    .protocol_err  (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    @(negedge clk);
    #1;
    checks++;
    if ({req_rdy, ret_valid, mem_rd_req, mem_rd_type, mem_rd_addr, mem_rd_size, protocol_err} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b ret=%b req=%b type=%h addr=%h size=%h err=%b exp all 0",
               req_rdy, ret_valid, mem_rd_req, mem_rd_type, mem_rd_addr, mem_rd_size, protocol_err);
    end
    checks++;
    if (ret_data !== '0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", ret_data);
    end
    resetn = 1'b1;
  endtask

  task automatic test_single;
    @(negedge clk);
    req_valid = 3'b010;
    req_type[5:3] = 3'b010;
    req_addr[63:32] = 32'h1FC0_0004;
    req_size[5:3] = 3'd1;
    #1;
    checks++;
    if (req_rdy !== 3'b010) begin errors++; $display("FAIL single_rdy got %b exp 010", req_rdy); end
    @(negedge clk);
    req_valid = 3'b000;
    mem_rd_rdy = 1'b1;
    #1;
    checks++;
    if ({mem_rd_req, mem_rd_type, mem_rd_addr, mem_rd_size} !== {1'b1, 3'b010, 32'h1FC0_0004, 3'd1}) begin
      errors++;
      $display("FAIL single_issue got req=%b type=%b addr=%h size=%0d exp 1 010 1fc00004 1",
               mem_rd_req, mem_rd_type, mem_rd_addr, mem_rd_size);
    end
    @(negedge clk);
    mem_rd_rdy = 1'b0;
    #1;
    checks++;
    if (mem_rd_req !== 1'b0 || ret_valid !== 3'b000) begin
      errors++;
      $display("FAIL single_wait got req=%b ret=%b exp 0 000", mem_rd_req, ret_valid);
    end
    @(negedge clk);
    @(negedge clk);
    mem_ret_valid = 1'b1;
    mem_ret_data = 128'hA5;
    @(negedge clk);
    mem_ret_valid = 1'b0;
    mem_ret_data = '0;
    #1;
    checks++;
    if (ret_valid !== 3'b010 || ret_data !== 128'hA5) begin
      errors++;
      $display("FAIL single_ret got ret=%b data=%h exp 010 a5", ret_valid, ret_data);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ret_valid !== 3'b000 || ret_data !== 128'hA5 || protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL single_after got ret=%b data=%h err=%b exp 000 a5 0", ret_valid, ret_data, protocol_err);
    end
  endtask

  task automatic test_round_robin;
    logic [2:0]   exp_oh;
    logic [31:0]  exp_addr;
    logic [127:0] exp_data;
    int           g;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    req_type = {3'b100, 3'b100, 3'b100};
    req_addr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    req_size = {3'd0, 3'd1, 3'd0};
    req_valid = 3'b111;
    for (int n = 0; n < 4; n++) begin
      g = n % 3;
      exp_oh = 3'b001 << g;
      exp_addr = 32'((g + 1) * 256);
      exp_data = 128'(32'h1000 + n);
      #1;
      checks++;
      if (req_rdy !== exp_oh) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", n, req_rdy, exp_oh); end
      @(negedge clk);
      mem_rd_rdy = 1'b1;
      #1;
      checks++;
      if ({mem_rd_req, mem_rd_type, mem_rd_addr, mem_rd_size} !== {1'b1, 3'b100, exp_addr, 3'd2}) begin
        errors++;
        $display("FAIL rr_issue%0d got req=%b type=%b addr=%h size=%0d exp 1 100 %h 2",
                 n, mem_rd_req, mem_rd_type, mem_rd_addr, mem_rd_size, exp_addr);
      end
      @(negedge clk);
      mem_rd_rdy = 1'b0;
      mem_ret_valid = 1'b1;
      mem_ret_data = exp_data;
      @(negedge clk);
      mem_ret_valid = 1'b0;
      if (n == 3) req_valid = 3'b000;
      #1;
      checks++;
      if (ret_valid !== exp_oh || ret_data !== exp_data) begin
        errors++;
        $display("FAIL rr_ret%0d got ret=%b data=%h exp %b %h", n, ret_valid, ret_data, exp_oh, exp_data);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall;
    @(negedge clk);
    req_valid = 3'b100;
    req_type[8:6] = 3'b010;
    req_addr[95:64] = 32'h0000_ABC0;
    req_size[8:6] = 3'd0;
    #1;
    checks++;
    if (req_rdy !== 3'b100) begin errors++; $display("FAIL stall_rdy got %b exp 100", req_rdy); end
    @(negedge clk);
    req_valid = 3'b011;
    mem_rd_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if ({mem_rd_req, mem_rd_type, mem_rd_addr, mem_rd_size, req_rdy} !== {1'b1, 3'b010, 32'h0000_ABC0, 3'd0, 3'b000}) begin
        errors++;
        $display("FAIL stall_hold%0d got req=%b type=%b addr=%h size=%0d rdy=%b exp 1 010 0000abc0 0 000",
                 k, mem_rd_req, mem_rd_type, mem_rd_addr, mem_rd_size, req_rdy);
      end
      @(negedge clk);
    end
    mem_rd_rdy = 1'b1;
    #1;
    checks++;
    if (mem_rd_req !== 1'b1) begin errors++; $display("FAIL stall_release got %b exp 1", mem_rd_req); end
    @(negedge clk);
    mem_rd_rdy = 1'b0;
    mem_ret_valid = 1'b1;
    mem_ret_data = 128'hDEAD_BEEF;
    #1;
    checks++;
    if (req_rdy !== 3'b000) begin errors++; $display("FAIL stall_wait_rdy got %b exp 000", req_rdy); end
    @(negedge clk);
    mem_ret_valid = 1'b0;
    #1;
    checks++;
    if (ret_valid !== 3'b100 || ret_data !== 128'hDEAD_BEEF || req_rdy !== 3'b000) begin
      errors++;
      $display("FAIL stall_ret got ret=%b data=%h rdy=%b exp 100 deadbeef 000", ret_valid, ret_data, req_rdy);
    end
    req_valid = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_stray;
    @(negedge clk);
    mem_ret_valid = 1'b1;
    mem_ret_data = '1;
    @(negedge clk);
    mem_ret_valid = 1'b0;
    mem_ret_data = '0;
    #1;
    checks++;
    if (protocol_err !== 1'b1 || ret_valid !== 3'b000 || ret_data !== 128'hDEAD_BEEF) begin
      errors++;
      $display("FAIL stray_flag got err=%b ret=%b data=%h exp 1 000 deadbeef", protocol_err, ret_valid, ret_data);
    end
    @(negedge clk);
    req_valid = 3'b001;
    req_type[2:0] = 3'b010;
    req_addr[31:0] = 32'h0000_2000;
    req_size[2:0] = 3'd2;
    #1;
    checks++;
    if (req_rdy !== 3'b001 || protocol_err !== 1'b1) begin
      errors++;
      $display("FAIL stray_next_rdy got rdy=%b err=%b exp 001 1", req_rdy, protocol_err);
    end
    @(negedge clk);
    req_valid = 3'b000;
    mem_rd_rdy = 1'b1;
    #1;
    checks++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== 32'h0000_2000) begin
      errors++;
      $display("FAIL stray_next_issue got req=%b addr=%h exp 1 00002000", mem_rd_req, mem_rd_addr);
    end
    @(negedge clk);
    mem_rd_rdy = 1'b0;
    mem_ret_valid = 1'b1;
    mem_ret_data = 128'h5555;
    @(negedge clk);
    mem_ret_valid = 1'b0;
    #1;
    checks++;
    if (ret_valid !== 3'b001 || ret_data !== 128'h5555 || protocol_err !== 1'b1) begin
      errors++;
      $display("FAIL stray_next_ret got ret=%b data=%h err=%b exp 001 5555 1", ret_valid, ret_data, protocol_err);
    end
  endtask

  task automatic test_reset_mid_wait;
    @(negedge clk);
    req_valid = 3'b010;
    #1;
    checks++;
    if (req_rdy !== 3'b010) begin errors++; $display("FAIL midrst_rdy got %b exp 010", req_rdy); end
    @(negedge clk);
    req_valid = 3'b000;
    mem_rd_rdy = 1'b1;
    @(negedge clk);
    mem_rd_rdy = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if ({req_rdy, ret_valid, mem_rd_req, mem_rd_type, mem_rd_addr, mem_rd_size, protocol_err} !== '0 || ret_data !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got rdy=%b ret=%b req=%b type=%h addr=%h size=%h err=%b data=%h exp all 0",
               req_rdy, ret_valid, mem_rd_req, mem_rd_type, mem_rd_addr, mem_rd_size, protocol_err, ret_data);
    end
    @(negedge clk);
    req_valid = 3'b100;
    mem_ret_valid = 1'b1;
    mem_ret_data = 128'h77;
    #1;
    checks++;
    if (req_rdy !== 3'b100 || ret_valid !== 3'b000) begin
      errors++;
      $display("FAIL midrst_grant got rdy=%b ret=%b exp 100 000", req_rdy, ret_valid);
    end
    @(negedge clk);
    req_valid = 3'b000;
    mem_ret_valid = 1'b0;
    mem_rd_rdy = 1'b1;
    #1;
    checks++;
    if (protocol_err !== 1'b1 || ret_valid !== 3'b000 || mem_rd_req !== 1'b1 || mem_rd_addr !== 32'h0000_ABC0) begin
      errors++;
      $display("FAIL midrst_late got err=%b ret=%b req=%b addr=%h exp 1 000 1 0000abc0",
               protocol_err, ret_valid, mem_rd_req, mem_rd_addr);
    end
    @(negedge clk);
    mem_rd_rdy = 1'b0;
    mem_ret_valid = 1'b1;
    mem_ret_data = 128'h88;
    @(negedge clk);
    mem_ret_valid = 1'b0;
    #1;
    checks++;
    if (ret_valid !== 3'b100 || ret_data !== 128'h88) begin
      errors++;
      $display("FAIL midrst_ret got ret=%b data=%h exp 100 88", ret_valid, ret_data);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    req_valid = 3'b001;
    req_type[2:0] = 3'b100;
    req_addr[31:0] = 32'h0000_3000;
    req_size[2:0] = 3'd0;
    #1;
    checks++;
    if (req_rdy !== 3'b001 || protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_rdy1 got rdy=%b err=%b exp 001 0", req_rdy, protocol_err);
    end
    @(negedge clk);
    mem_rd_rdy = 1'b1;
    #1;
    checks++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== 32'h0000_3000 || mem_rd_size !== 3'd2) begin
      errors++;
      $display("FAIL b2b_issue1 got req=%b addr=%h size=%0d exp 1 00003000 2", mem_rd_req, mem_rd_addr, mem_rd_size);
    end
    @(negedge clk);
    mem_rd_rdy = 1'b0;
    mem_ret_valid = 1'b1;
    mem_ret_data = 128'h11;
    #1;
    checks++;
    if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL b2b_wait1 got %b exp 0", mem_rd_req); end
    @(negedge clk);
    mem_ret_valid = 1'b0;
    #1;
    checks++;
    if (ret_valid !== 3'b001 || req_rdy !== 3'b000 || ret_data !== 128'h11) begin
      errors++;
      $display("FAIL b2b_ret1 got ret=%b rdy=%b data=%h exp 001 000 11", ret_valid, req_rdy, ret_data);
    end
    @(negedge clk);
    req_addr[31:0] = 32'h0000_3040;
    #1;
    checks++;
    if (req_rdy !== 3'b001) begin errors++; $display("FAIL b2b_rdy2 got %b exp 001", req_rdy); end
    @(negedge clk);
    mem_rd_rdy = 1'b1;
    #1;
    checks++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== 32'h0000_3040) begin
      errors++;
      $display("FAIL b2b_issue2 got req=%b addr=%h exp 1 00003040", mem_rd_req, mem_rd_addr);
    end
    @(negedge clk);
    mem_rd_rdy = 1'b0;
    mem_ret_valid = 1'b1;
    mem_ret_data = 128'h22;
    @(negedge clk);
    mem_ret_valid = 1'b0;
    req_valid = 3'b000;
    #1;
    checks++;
    if (ret_valid !== 3'b001 || ret_data !== 128'h22) begin
      errors++;
      $display("FAIL b2b_ret2 got ret=%b data=%h exp 001 22", ret_valid, ret_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    req_valid = '0;
    req_type = '0;
    req_addr = '0;
    req_size = '0;
    mem_rd_rdy = 1'b0;
    mem_ret_valid = 1'b0;
    mem_ret_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_stray();
    test_reset_mid_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
